uart_tx_fifo_cfg: RTL
=====================

// Module: uart_tx_fifo_cfg
// PURPOSE
//  Parametrised UART transmitter: runtime baud divisor, 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
//  Front-end FIFO with valid/ready push; consecutive frames are sent back-to-back with no idle gap.
//  Sits between a byte producer (host/accelerator logic) and the board TX pin.
//  Successor to the fixed 8N1 single-byte transmitter.
// PARAMETERS
//  DATA_BITS   8   frame data bits, legal 5..8; width of i_Tx_Byte
//  FIFO_DEPTH  4   FIFO entries, power of two >= 2
//  DIV_W       16  width of i_Clks_Per_Bit
// PORTS
//  i_Clock         in   1          sole clock, rising edge
//  i_Rst_n         in   1          async active-low reset
//  i_Clks_Per_Bit  in   DIV_W      clocks per bit; values < 2 are treated as 2
//  i_Parity_En     in   1          1 = append parity bit
//  i_Parity_Odd    in   1          0 = even parity, 1 = odd parity
//  i_Two_Stop      in   1          0 = 1 stop bit, 1 = 2 stop bits
//  i_Tx_DV         in   1          push strobe, one byte per cycle
//  i_Tx_Byte       in   DATA_BITS  byte to push
//  o_Tx_Ready      out  1          FIFO not full
//  o_Overflow      out  1          1-cycle pulse: push dropped because FIFO was full
//  o_Fifo_Count    out  clog2(D)+1 occupied entries
//  o_Tx_Active     out  1          frame in progress
//  o_Tx_Serial     out  1          serial line, registered
//  o_Tx_Done       out  1          1-cycle pulse per completed frame
// BEHAVIOUR
//  - Reset, async: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Tx_Ready=1, o_Fifo_Count=0.
//    FIFO is emptied, FSM goes to IDLE, counters clear. Reset mid-frame aborts the frame and drives the line high at once.
//  - Push: accepted when i_Tx_DV=1 and FIFO not full at that edge. Push while full is dropped and pulses o_Overflow,
//    even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE: when the FIFO is non-empty, pop the head entry, latch data and all config inputs, and enter START next cycle.
//    START: line 0 for N cycles.
//    DATA: DATA_BITS bits LSB first, N cycles each.
//    PARITY (only if latched enable): line = ^data ^ odd, N cycles.
//    STOP: line 1 for N cycles, or 2N cycles if two stop bits are latched.
//  - N is the latched, clamped divisor. A cycle counter runs 0..N-1, and the bit advances when the counter reaches N-1.
//    Config inputs changed mid-frame have no effect until the next frame.
//  - End of the last stop cycle: o_Tx_Done pulses in the following cycle.
//    If the FIFO is non-empty at that edge, pop it and go straight to START; that cycle is the first start-bit cycle, and o_Tx_Active stays 1.
//    Otherwise go to IDLE and drop o_Tx_Active with the Done pulse.
//  - o_Tx_Active rises in the first START cycle.
//  - Frame length in cycles: N*(1 + DATA_BITS + P + S), where P = parity enable (0/1) and S = stop bits (1/2).
//  - Divisor arithmetic is unsigned DIV_W bits; no other wrap is possible.
//    FIFO pointers are clog2(D) bits and wrap modulo FIFO_DEPTH.
// STRUCTURE
//  - Shared package uart_pkg: FSM state encoding (3 bits) and parity mode constants.
//  - One sub-module: uart_sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count, async active-low reset).
//  - Top level holds the FSM, baud counter, bit index, stop-bit counter and parity computation.
// TESTING
//  1. N=4, 8N1, push 0xA5 in IDLE -> line 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4;
//     40-cycle frame; o_Tx_Done pulses once, 1 cycle after the stop bit.
//  2. N=4, parity even, push 0x07 -> parity bit 1; parity odd -> parity bit 0; frame 44 cycles.
//  3. i_Two_Stop=1, N=3, 8N2 byte 0x00 -> stop high for 6 cycles; frame 33 cycles.
//  4. FIFO_DEPTH=4, N=4, push 0x11,0x22,0x33 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycle;
//     3 Done pulses 40 cycles apart; o_Tx_Active never drops between frames.
//  5. FIFO_DEPTH=4, pushes on 6 consecutive cycles from IDLE -> 5 accepted (1 popped + 4 queued);
//     6th push pulses o_Overflow with o_Tx_Ready=0; 5 frames transmitted.
//  6. Deassert i_Rst_n mid-DATA -> same cycle: o_Tx_Serial=1, o_Tx_Active=0, o_Fifo_Count=0.
//     After release, a new push of 0x5A sends a clean frame.
//     Also: i_Clks_Per_Bit=0 gives 2-cycle bits, and changing the divisor mid-frame does not alter the current frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the configurable UART transmitter:
//                FSM state encoding, parity mode values and a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Transmitter FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Parity mode select values
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Parity bit for a zero-extended data word; zero padding does not change XOR
   function automatic logic calc_parity(input logic [7:0] data, input logic mode);
      return (mode == PAR_EVEN) ? (^data) : ~(^data);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. Head entry is
//                always visible on data_o; push while full and pop while
//                empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Storage array: written only on an accepted push, never reset
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally modulo DEPTH; count tracks net push/pop
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_cfg
//  Description : Configurable UART transmitter (runtime divisor, 5-8 data
//                bits, optional even/odd parity, 1 or 2 stop bits) fed by a
//                small FIFO. Queued frames are sent back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_n,
   input  logic [DIV_W-1:0]              i_Clks_Per_Bit,
   input  logic                          i_Parity_En,
   input  logic                          i_Parity_Odd,
   input  logic                          i_Two_Stop,
   input  logic                          i_Tx_DV,
   input  logic [DATA_BITS-1:0]          i_Tx_Byte,
   output logic                          o_Tx_Ready,
   output logic                          o_Overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Done
);

   localparam int BIT_W = $clog2(DATA_BITS);

   // FIFO interface
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;

   // Frame state
   logic [2:0]           state_q,    state_d;
   logic [DIV_W-1:0]     cnt_q,      cnt_d;
   logic [DIV_W-1:0]     n_q,        n_d;
   logic [BIT_W-1:0]     bit_q,      bit_d;
   logic                 stop_q,     stop_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic                 par_en_q,   par_en_d;
   logic                 two_stop_q, two_stop_d;
   logic                 par_bit_q,  par_bit_d;
   logic                 serial_q,   serial_d;
   logic                 active_q,   active_d;
   logic                 done_q,     done_d;
   logic                 ovf_q;

   logic [DIV_W-1:0]     div_clamped;
   logic                 bit_end;
   logic                 load_frame;

   uart_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk_i   (i_Clock),
      .rst_n_i (i_Rst_n),
      .push_i  (i_Tx_DV),
      .data_i  (i_Tx_Byte),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (o_Fifo_Count)
   );

   // Divisors below 2 would leave no room for the counter, so clamp them
   assign div_clamped = (i_Clks_Per_Bit < DIV_W'(2)) ? DIV_W'(2) : i_Clks_Per_Bit;
   assign bit_end     = (cnt_q == (n_q - DIV_W'(1)));

   assign o_Tx_Ready  = ~fifo_full;
   assign o_Overflow  = ovf_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;

   // Next-state logic: bit sequencing, baud counting and frame loading
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      par_bit_d  = par_bit_q;
      serial_d   = serial_q;
      active_d   = active_q;
      done_d     = 1'b0;
      load_frame = 1'b0;
      fifo_pop   = 1'b0;

      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load_frame = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               state_d  = ST_DATA;
               bit_d    = '0;
               serial_d = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  if (par_en_q) begin
                     state_d  = ST_PARITY;
                     serial_d = par_bit_q;
                  end else begin
                     state_d  = ST_STOP;
                     stop_d   = 1'b0;
                     serial_d = 1'b1;
                  end
               end else begin
                  bit_d    = bit_q + BIT_W'(1);
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d  = ST_STOP;
               stop_d   = 1'b0;
               serial_d = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               // stop_q counts completed stop bits; two_stop_q selects the last one
               if (stop_q == two_stop_q) begin
                  done_d = 1'b1;
                  if (!fifo_empty) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d  = ST_IDLE;
                     active_d = 1'b0;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
         end
      endcase

      // Pop the head entry and capture the frame configuration as one unit
      if (load_frame) begin
         fifo_pop   = 1'b1;
         state_d    = ST_START;
         cnt_d      = '0;
         n_d        = div_clamped;
         shift_d    = fifo_data;
         par_en_d   = i_Parity_En;
         two_stop_d = i_Two_Stop;
         par_bit_d  = calc_parity(8'(fifo_data), i_Parity_Odd);
         serial_d   = 1'b0;
         active_d   = 1'b1;
      end
   end

   // State registers; reset drives the line idle-high immediately
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         n_q        <= DIV_W'(2);
         bit_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         par_bit_q  <= 1'b0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         bit_q      <= bit_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         par_bit_q  <= par_bit_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
         ovf_q      <= i_Tx_DV & fifo_full;
      end
   end

endmodule
`default_nettype wire
